// File: rtl/maze_walker.sv
// Wall-follower maze solver over an external synchronous bitmap RAM (0=free, 1=wall).
// Optional step budget enabled by defining MAZE_STEP_LIMIT_EN.
module maze_walker #(
  parameter int MAZE_WIDTH = 6,
  parameter int MAX_ROW    = 63,
  parameter int MAX_COL    = 63,
  parameter int STEP_WIDTH = 16,
  parameter int MAX_STEPS  = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  hand,
  input  logic [1:0]            start_dir,
  input  logic [MAZE_WIDTH-1:0] starting_row,
  input  logic [MAZE_WIDTH-1:0] starting_col,
  input  logic                  maze_in,
  output logic [MAZE_WIDTH-1:0] row,
  output logic [MAZE_WIDTH-1:0] col,
  output logic                  maze_oe,
  output logic                  maze_we,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic                  timeout,
  output logic [STEP_WIDTH-1:0] steps
);

  typedef enum logic [2:0] {S_IDLE, S_MARK, S_PROBE, S_EVAL, S_DONE} state_t;

  localparam logic [MAZE_WIDTH-1:0] LP_MAX_ROW = MAZE_WIDTH'(MAX_ROW);
  localparam logic [MAZE_WIDTH-1:0] LP_MAX_COL = MAZE_WIDTH'(MAX_COL);

  state_t                r_state, w_next;
  logic [MAZE_WIDTH-1:0] r_cur_row, r_cur_col, r_row, r_col;
  logic                  r_inr, r_hand, r_fail;
  logic [1:0]            r_dir, r_try;
  logic [STEP_WIDTH-1:0] r_steps;

  logic [1:0]            w_ptry, w_pdir, w_tdir;
  logic [MAZE_WIDTH-1:0] w_nb_row, w_nb_col;
  logic                  w_nb_ok, w_at_exit, w_limit, w_move;

  // Heading offset for the t-th try: side turn first, then straight, other side, back.
  function automatic logic [1:0] try_dir(input logic [1:0] d, input logic h, input logic [1:0] t);
    logic [1:0] off;
    case (t)
      2'd0:    off = h ? 2'd3 : 2'd1;
      2'd1:    off = 2'd0;
      2'd2:    off = h ? 2'd1 : 2'd3;
      default: off = 2'd2;
    endcase
    return d + off;
  endfunction

  assign w_ptry = (r_state == S_MARK) ? 2'd0 : r_try + 2'd1;
  assign w_pdir = try_dir(r_dir, r_hand, w_ptry);
  assign w_tdir = try_dir(r_dir, r_hand, r_try);

  always_comb begin
    w_nb_row = r_cur_row;
    w_nb_col = r_cur_col;
    w_nb_ok  = 1'b0;
    case (w_pdir)
      2'd0: begin w_nb_ok = (r_cur_row != '0);         w_nb_row = r_cur_row - 1'b1; end
      2'd1: begin w_nb_ok = (r_cur_col != LP_MAX_COL); w_nb_col = r_cur_col + 1'b1; end
      2'd2: begin w_nb_ok = (r_cur_row != LP_MAX_ROW); w_nb_row = r_cur_row + 1'b1; end
      default: begin w_nb_ok = (r_cur_col != '0);      w_nb_col = r_cur_col - 1'b1; end
    endcase
  end

  assign w_at_exit = ((r_cur_row == '0) || (r_cur_row == LP_MAX_ROW) ||
                      (r_cur_col == '0) || (r_cur_col == LP_MAX_COL)) && (r_steps != '0);
  assign w_move    = !maze_in && r_inr;

`ifdef MAZE_STEP_LIMIT_EN
  localparam logic [STEP_WIDTH-1:0] LP_MAX_STEPS = STEP_WIDTH'(MAX_STEPS);
  logic r_timeout;
  assign w_limit = (r_steps == LP_MAX_STEPS);
  assign timeout = r_timeout;
`else
  assign w_limit = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_MARK;
      S_MARK:         w_next = (w_at_exit || w_limit) ? S_DONE : S_PROBE;
      S_PROBE:        w_next = S_EVAL;
      S_EVAL: begin
        if (w_move)              w_next = S_MARK;
        else if (r_try == 2'd3)  w_next = S_DONE;
        else                     w_next = S_PROBE;
      end
      default:        w_next = S_IDLE;
    endcase
  end

  // The address register always holds the cell the current state works on:
  // the current cell in MARK, the probed neighbour in PROBE/EVAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_row <= '0;
      r_cur_col <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_inr     <= 1'b0;
      r_hand    <= 1'b0;
      r_fail    <= 1'b0;
      r_dir     <= 2'd0;
      r_try     <= 2'd0;
      r_steps   <= '0;
`ifdef MAZE_STEP_LIMIT_EN
      r_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) begin
          r_hand    <= hand;
          r_dir     <= start_dir;
          r_cur_row <= starting_row;
          r_cur_col <= starting_col;
          r_row     <= starting_row;
          r_col     <= starting_col;
          r_try     <= 2'd0;
          r_steps   <= '0;
          r_fail    <= 1'b0;
`ifdef MAZE_STEP_LIMIT_EN
          r_timeout <= 1'b0;
`endif
        end
        S_MARK: begin
          if (!w_at_exit && w_limit) begin
            r_fail    <= 1'b1;
`ifdef MAZE_STEP_LIMIT_EN
            r_timeout <= 1'b1;
`endif
          end else if (!w_at_exit) begin
            r_try <= 2'd0;
            r_row <= w_nb_row;
            r_col <= w_nb_col;
            r_inr <= w_nb_ok;
          end
        end
        S_EVAL: begin
          if (w_move) begin
            r_cur_row <= r_row;
            r_cur_col <= r_col;
            r_dir     <= w_tdir;
            if (r_steps != '1) r_steps <= r_steps + 1'b1;
          end else if (r_try == 2'd3) begin
            r_fail <= 1'b1;
          end else begin
            r_try <= w_ptry;
            r_row <= w_nb_row;
            r_col <= w_nb_col;
            r_inr <= w_nb_ok;
          end
        end
        default: ;
      endcase
    end
  end

  assign row     = r_row;
  assign col     = r_col;
  assign maze_we = (r_state == S_MARK);
  assign maze_oe = (r_state == S_PROBE) && r_inr;
  assign busy    = (r_state == S_MARK) || (r_state == S_PROBE) || (r_state == S_EVAL);
  assign done    = (r_state == S_DONE);
  assign fail    = r_fail;
  assign steps   = r_steps;

endmodule
